midi_msg_tx: RTL
================

MIDI_MSG_TX -- requirements
Module: midi_msg_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 800, CLOCK_25 cycles per MIDI bit (31250 baud).
REQ-002 SHALL have port CLOCK_25  in  1  system clock, 25 MHz.
REQ-003 SHALL have port reset_reg_N  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port msg_valid  in  1  message offered.
REQ-005 SHALL have port msg_ready  out  1  message accepted when msg_valid && msg_ready are both high at a rising edge.
REQ-006 SHALL have port msg_status  in  8  status byte.
REQ-007 SHALL have port msg_data1  in  8  first data byte.
REQ-008 SHALL have port msg_data2  in  8  second data byte.
REQ-009 SHALL have port rt_valid  in  1  real-time byte offered.
REQ-010 SHALL have port rt_ready  out  1  real-time byte accepted when rt_valid && rt_ready.
REQ-011 SHALL have port rt_byte  in  8  real-time byte (0xF8-0xFF).
REQ-012 SHALL have port run_status_en  in  1  enables running-status compression.
REQ-013 SHALL have port midi_txd  out  1  serial MIDI output, idle high.
REQ-014 SHALL have port busy  out  1  high while a message or frame is in progress.
REQ-015 SHALL have port err_pulse  out  1  one-cycle pulse on a rejected message.

Function
REQ-016 SHALL frame each byte as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit lasts exactly CLK_DIV cycles (10*CLK_DIV cycles per frame).
REQ-017 SHALL drive midi_txd low (start bit) on the first rising edge after the acceptance edge.
REQ-018 SHALL send the bytes of one message back-to-back, with no idle time between stop bit and next start bit.
REQ-019 SHALL use message FSM states IDLE, ST, D1, D2; a state advances when the serializer reports the byte loaded.
REQ-020 SHALL take data-byte count from msg_status: 0x8n/9n/An/Bn/En and F2 -> 2; Cn/Dn, F1, F3 -> 1; F0, F6, F7 -> 0. Unused data inputs are ignored.
REQ-021 SHALL force bit 7 of each transmitted data byte to 0.
REQ-022 SHALL reject msg_status < 0x80 or >= 0xF8: err_pulse=1 for one cycle, nothing sent, msg_ready stays high.
REQ-023 SHALL hold msg_ready high only in IDLE with the serializer idle and no real-time byte pending.
REQ-024 SHALL keep a last_status register: set on each 0x80-0xEF status accepted; cleared to 0x00 on F0-F7; unchanged by real-time bytes.
REQ-025 SHALL omit the status byte when run_status_en=1 and msg_status equals last_status (0x80-0xEF only).
REQ-026 SHALL, when run_status_en=0, always send the status byte; last_status is still tracked.
REQ-027 SHALL raise rt_ready only at byte boundaries (serializer idle), including between bytes of a message.
REQ-028 SHALL, when rt_valid and a pending message byte coincide at a boundary, send the real-time byte first.
REQ-029 SHALL never interrupt a frame in progress.
REQ-030 SHALL accept rt_byte < 0xF8 (rt_ready handshake completes) but not transmit it.
REQ-031 SHALL not let msg_valid/msg_ready and rt_valid/rt_ready both complete in the same cycle; real-time wins.
REQ-032 SHALL hold busy high from the acceptance edge until the final stop bit completes.

Reset
REQ-033 SHALL, while reset_reg_N=0, force midi_txd=1, msg_ready=0, rt_ready=0, busy=0, err_pulse=0, last_status=0x00, FSM=IDLE, baud counter=0.
REQ-034 SHALL abandon a partial frame on reset mid-operation; the first message after release sends its status byte.
REQ-035 SHALL assert msg_ready on the first rising edge after reset release.

Structure
REQ-036 SHALL place CLK_DIV default, status-class constants and the data-length function in shared package midi_pkg.
REQ-037 SHALL implement bit timing and framing in sub-module midi_tx_serializer (load, byte, ready, txd); message FSM, running status and real-time arbitration stay in midi_msg_tx.

Verification
REQ-038 SHALL cover: reset, then send 0x90,0x3C,0x64 -> frames 0x90,0x3C,0x64 totalling 24000 cycles; msg_ready returns high after them.
REQ-039 SHALL cover: then send 0x90,0x40,0x7F with run_status_en=1 -> only 0x40,0x7F (16000 cycles); repeat with run_status_en=0 -> three frames.
REQ-040 SHALL cover: send 0xC5,0x10,0x55 -> frames 0xC5,0x10 only; data 0x85 sent as 0x05.
REQ-041 SHALL cover: rt 0xF8 during the 0x90 frame -> order 0x90,0xF8,0x3C,0x64; a following 0x90 message is compressed.
REQ-042 SHALL cover: send status 0x3C -> err_pulse for 1 cycle, midi_txd stays 1; send 0xF8 as msg -> same.
REQ-043 SHALL cover: reset mid data bit -> midi_txd=1 immediately; after release 0x90,0x3C,0x64 sends three frames.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared MIDI constants, message FSM encodings and the status-to-data-length decode.
// Imported by the serializer and the message transmitter.
package midi_pkg;

    localparam int CLK_DIV_DEFAULT = 800;

    localparam logic [7:0] STATUS_MIN   = 8'h80;
    localparam logic [7:0] SYSCOM_MIN   = 8'hF0;
    localparam logic [7:0] REALTIME_MIN = 8'hF8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ST   = 2'd1;
    localparam logic [1:0] D1   = 2'd2;
    localparam logic [1:0] D2   = 2'd3;

    // Number of data bytes that follow a given status byte.
    function automatic logic [1:0] data_len(input logic [7:0] status);
        logic [1:0] n;
        n = 2'd0;
        case (status[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: n = 2'd2;
            4'hC, 4'hD:                   n = 2'd1;
            4'hF: begin
                case (status[3:0])
                    4'h2:       n = 2'd2;
                    4'h1, 4'h3: n = 2'd1;
                    default:    n = 2'd0;
                endcase
            end
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    function automatic logic is_msg_status(input logic [7:0] status);
        return (status >= STATUS_MIN) && (status < REALTIME_MIN);
    endfunction

endpackage

// File: rtl/midi_tx_serializer.sv
// 8N1 UART framer for MIDI: start bit, 8 data bits LSB first, stop bit, CLK_DIV cycles per bit.
// ready is also high in the last cycle of a stop bit so a new byte follows with no idle gap.
module midi_tx_serializer
    import midi_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic       CLOCK_25,
    input  logic       reset_reg_N,
    input  logic       load,
    input  logic [7:0] tx_byte,
    output logic       ready,
    output logic       active,
    output logic       txd
);

    localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [3:0]    BIT_STOP = 4'd9;

    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [7:0]    tx_shift;
    logic          bit_last;

    assign bit_last = (cnt == CNT_LAST);
    assign ready    = !active || ((bit_idx == BIT_STOP) && bit_last);

    always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            active   <= 1'b0;
            cnt      <= '0;
            bit_idx  <= 4'd0;
            tx_shift <= 8'h00;
            txd      <= 1'b1;
        end else if (load && ready) begin
            active   <= 1'b1;
            cnt      <= '0;
            bit_idx  <= 4'd0;
            tx_shift <= tx_byte;
            txd      <= 1'b0;
        end else if (active) begin
            if (bit_last) begin
                cnt <= '0;
                if (bit_idx == BIT_STOP) begin
                    active <= 1'b0;
                end else begin
                    // bit_idx names the bit just finished; data bit n follows bit n.
                    bit_idx <= bit_idx + 4'd1;
                    txd     <= (bit_idx == 4'd8) ? 1'b1 : tx_shift[bit_idx[2:0]];
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/midi_msg_tx.sv
// MIDI message transmitter: channel/system message FSM with running-status compression,
// real-time byte insertion at byte boundaries, and an 8N1 serializer.
module midi_msg_tx
    import midi_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic       CLOCK_25,
    input  logic       reset_reg_N,
    input  logic       msg_valid,
    output logic       msg_ready,
    input  logic [7:0] msg_status,
    input  logic [7:0] msg_data1,
    input  logic [7:0] msg_data2,
    input  logic       rt_valid,
    output logic       rt_ready,
    input  logic [7:0] rt_byte,
    input  logic       run_status_en,
    output logic       midi_txd,
    output logic       busy,
    output logic       err_pulse,
    output logic [1:0] state_dbg
);

    logic [1:0] state;
    logic [1:0] len;
    logic [7:0] status_q;
    logic [7:0] data1_q;
    logic [7:0] data2_q;
    logic [7:0] last_status;
    logic       out_of_reset;

    logic       ser_load;
    logic       ser_ready;
    logic       ser_active;
    logic [7:0] ser_byte;
    logic [7:0] cur_byte;

    logic       msg_fire;
    logic       rt_fire;
    logic       rt_send;
    logic       msg_load;
    logic       status_ok;
    logic       skip_status;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // ready never depends on the same channel's valid; msg_ready drops while rt_valid is
    // high, so a real-time byte always wins a simultaneous offer.
    assign rt_ready  = out_of_reset && ser_ready;
    assign msg_ready = out_of_reset && (state == IDLE) && !ser_active && !rt_valid;

    assign rt_fire   = rt_valid && rt_ready;
    assign rt_send   = rt_fire && (rt_byte >= REALTIME_MIN);
    assign msg_fire  = msg_valid && msg_ready;
    assign msg_load  = ser_ready && (state != IDLE) && !rt_fire;

    assign status_ok   = is_msg_status(msg_status);
    assign skip_status = run_status_en && (msg_status == last_status) && (msg_status < SYSCOM_MIN);

    always_comb begin
        cur_byte = status_q;
        case (state)
            D1:      cur_byte = data1_q;
            D2:      cur_byte = data2_q;
            default: cur_byte = status_q;
        endcase
    end

    assign ser_load  = rt_send || msg_load;
    assign ser_byte  = rt_send ? rt_byte : cur_byte;
    assign busy      = (state != IDLE) || ser_active;
    assign state_dbg = state;

    always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state        <= IDLE;
            len          <= 2'd0;
            status_q     <= 8'h00;
            data1_q      <= 8'h00;
            data2_q      <= 8'h00;
            last_status  <= 8'h00;
            err_pulse    <= 1'b0;
            out_of_reset <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
            err_pulse    <= msg_fire && !status_ok;
            if (msg_fire && status_ok) begin
                status_q    <= msg_status;
                data1_q     <= msg_data1 & 8'h7F;
                data2_q     <= msg_data2 & 8'h7F;
                len         <= data_len(msg_status);
                // Compressed messages are always channel messages, so D1 always exists.
                state       <= skip_status ? D1 : ST;
                last_status <= (msg_status < SYSCOM_MIN) ? msg_status : 8'h00;
            end else if (msg_load) begin
                case (state)
                    ST:      state <= (len == 2'd0) ? IDLE : D1;
                    D1:      state <= (len == 2'd2) ? D2 : IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    midi_tx_serializer #(
        .CLK_DIV(CLK_DIV)
    ) u_ser (
        .CLOCK_25   (CLOCK_25),
        .reset_reg_N(reset_reg_N),
        .load       (ser_load),
        .tx_byte    (ser_byte),
        .ready      (ser_ready),
        .active     (ser_active),
        .txd        (midi_txd)
    );

endmodule
